// File: rtl/mult_pkg.sv
// mult_pkg: shared width, state encoding and product type for the shift-add multiplier
package mult_pkg;
  localparam int WIDTH = 4;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  typedef logic [2*WIDTH-1:0] product_t;
endpackage

// File: rtl/adder.sv
// adder: combinational 4-bit adder with carry out
module adder (
  input  logic [3:0] a,
  input  logic [3:0] m,
  output logic [3:0] sum,
  output logic       carry
);
  assign {carry, sum} = {1'b0, a} + {1'b0, m};
endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: sequential unsigned multiplier, one add/shift step per cycle
module shift_add_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = mult_pkg::WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);
  localparam int ITERATIONS = WIDTH;
  localparam int CW = $clog2(ITERATIONS);
  if (WIDTH != 4) begin : g_width_check
    $error("shift_add_multiplier: WIDTH must equal the adder width (4)");
  end
  state_t state;
  logic [WIDTH-1:0] a_r, q, m, sum, a_add, a_nx, q_nx;
  logic c, carry, c_add;
  logic [CW-1:0] count;
  adder u_adder (.a(a_r), .m(m), .sum(sum), .carry(carry));
  // c is always 0 between steps, so the q[0]=0 path keeps {C,A} = {0,A}
  always_comb begin
    c_add = q[0] ? carry : c;
    a_add = q[0] ? sum : a_r;
    a_nx = {c_add, a_add[WIDTH-1:1]};
    q_nx = {a_add[0], q[WIDTH-1:1]};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      product <= '0;
      a_r <= '0;
      c <= 1'b0;
      q <= '0;
      m <= '0;
      count <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          busy <= start;
          if (start) begin
            m <= multiplicand;
            q <= multiplier;
            a_r <= '0;
            c <= 1'b0;
            count <= '0;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          a_r <= a_nx;
          q <= q_nx;
          c <= 1'b0;
          count <= count + 1'b1;
          if (count == CW'(ITERATIONS - 1)) begin
            product <= {a_nx, q_nx};
            busy <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
